// File: rtl/fifo_controller.sv
// Sequencer for the FSM-based FIFO: services one write or read transfer at a time,
// owns the RAM pointers, occupancy count and full/empty flags.
module fifo_controller #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              WB_LoadEnable,
  output logic              WB_Clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              RB_LoadEnable,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              wr_err,
  output logic              rd_err,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_LOAD   = 3'd1,
    WR_COMMIT = 3'd2,
    RD_FETCH  = 3'd3,
    RD_LOAD   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   wptr_r;
  logic [ADDR_W-1:0]   rptr_r;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W:0]     count_next_s;
  logic                full_r;
  logic                empty_r;
  logic                wr_err_r;
  logic                rd_err_r;
  logic                last_grant_wr_r;
  logic                wr_ok_s;
  logic                rd_ok_s;
  logic                grant_wr_s;
  logic                grant_rd_s;

  // Arbitration and next-state decode; requests only matter in IDLE.
  always_comb begin
    state_next_s = state_r;
    grant_wr_s   = 1'b0;
    grant_rd_s   = 1'b0;
    wr_ok_s      = wr_req & ~full_r;
    rd_ok_s      = rd_req & ~empty_r;
    case (state_r)
      IDLE: begin
        if (wr_ok_s && rd_ok_s) begin
          // Round-robin against the previous grant; write wins right after reset.
          if (last_grant_wr_r) begin
            grant_rd_s = 1'b1;
          end else begin
            grant_wr_s = 1'b1;
          end
        end else if (wr_ok_s) begin
          grant_wr_s = 1'b1;
        end else if (rd_ok_s) begin
          grant_rd_s = 1'b1;
        end else begin
          grant_wr_s = 1'b0;
        end
        if (grant_wr_s) begin
          state_next_s = WR_LOAD;
        end else if (grant_rd_s) begin
          state_next_s = RD_FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_LOAD:   state_next_s = WR_COMMIT;
      WR_COMMIT: state_next_s = IDLE;
      RD_FETCH:  state_next_s = RD_LOAD;
      RD_LOAD:   state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // Occupancy after the current cycle's commit, if any.
  always_comb begin
    count_next_s = count_r;
    case (state_r)
      WR_COMMIT: count_next_s = count_r + CNT_ONE_C;
      RD_LOAD:   count_next_s = count_r - CNT_ONE_C;
      default:   count_next_s = count_r;
    endcase
  end

  // State, pointers, occupancy, flags and error pulses.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r         <= IDLE;
      wptr_r          <= {ADDR_W{1'b0}};
      rptr_r          <= {ADDR_W{1'b0}};
      count_r         <= {(ADDR_W+1){1'b0}};
      full_r          <= 1'b0;
      empty_r         <= 1'b1;
      wr_err_r        <= 1'b0;
      rd_err_r        <= 1'b0;
      last_grant_wr_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      count_r  <= count_next_s;
      full_r   <= (count_next_s == DEPTH_C);
      empty_r  <= (count_next_s == {(ADDR_W+1){1'b0}});
      wr_err_r <= (state_r == IDLE) & wr_req & full_r;
      rd_err_r <= (state_r == IDLE) & rd_req & empty_r;
      if (grant_wr_s || grant_rd_s) begin
        last_grant_wr_r <= grant_wr_s;
      end else begin
        last_grant_wr_r <= last_grant_wr_r;
      end
      if (state_r == WR_COMMIT) begin
        wptr_r <= wptr_r + PTR_ONE_C;
      end else begin
        wptr_r <= wptr_r;
      end
      if (state_r == RD_LOAD) begin
        rptr_r <= rptr_r + PTR_ONE_C;
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // Strobes are decoded from state and forced low while reset is asserted.
  assign WB_LoadEnable = (state_r == WR_LOAD)   & ~Reset;
  assign mem_we        = (state_r == WR_COMMIT) & ~Reset;
  assign wr_ack        = (state_r == WR_COMMIT) & ~Reset;
  assign RB_LoadEnable = (state_r == RD_LOAD)   & ~Reset;
  assign rd_ack        = (state_r == RD_LOAD)   & ~Reset;
  assign WB_Clear      = ~Reset;

  assign mem_waddr = wptr_r;
  assign mem_raddr = rptr_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign wr_err    = wr_err_r;
  assign rd_err    = rd_err_r;

endmodule

// File: tb/tb_fifo_controller.sv
// Bench for fifo_controller: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fifo_controller;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          WB_LoadEnable, WB_Clear, mem_we, RB_LoadEnable;
  logic          wr_ack, rd_ack, wr_err, rd_err, full, empty;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0]   count;

  fifo_controller #(.ADDR_W(AW)) dut (
    .clk(clk), .Reset(Reset), .wr_req(wr_req), .rd_req(rd_req),
    .WB_LoadEnable(WB_LoadEnable), .WB_Clear(WB_Clear), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .RB_LoadEnable(RB_LoadEnable),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_err(wr_err), .rd_err(rd_err),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: a transfer in progress is (kind, cycles elapsed since grant).
  bit chk_en    = 1'b0;
  int m_phase   = 0;
  bit m_is_wr   = 1'b0;
  bit m_last_wr = 1'b0;
  int m_count   = 0;
  int m_wptr    = 0;
  int m_rptr    = 0;
  bit m_wr_err  = 1'b0;
  bit m_rd_err  = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit wok, rok;
      chk("WB_Clear",      WB_Clear,      !Reset);
      chk("WB_LoadEnable", WB_LoadEnable, !Reset && m_phase == 1 && m_is_wr);
      chk("mem_we",        mem_we,        !Reset && m_phase == 2 && m_is_wr);
      chk("wr_ack",        wr_ack,        !Reset && m_phase == 2 && m_is_wr);
      chk("RB_LoadEnable", RB_LoadEnable, !Reset && m_phase == 2 && !m_is_wr);
      chk("rd_ack",        rd_ack,        !Reset && m_phase == 2 && !m_is_wr);
      chk("mem_waddr",     mem_waddr,     m_wptr);
      chk("mem_raddr",     mem_raddr,     m_rptr);
      chk("count",         count,         m_count);
      chk("full",          full,          m_count == DEPTH);
      chk("empty",         empty,         m_count == 0);
      chk("wr_err",        wr_err,        m_wr_err);
      chk("rd_err",        rd_err,        m_rd_err);
      // Inputs are stable until the coming posedge, so advance the model now.
      if (Reset) begin
        m_phase = 0; m_is_wr = 1'b0; m_last_wr = 1'b0; m_count = 0;
        m_wptr = 0; m_rptr = 0; m_wr_err = 1'b0; m_rd_err = 1'b0;
      end else begin
        m_wr_err = (m_phase == 0) && wr_req && (m_count == DEPTH);
        m_rd_err = (m_phase == 0) && rd_req && (m_count == 0);
        if (m_phase == 0) begin
          wok = wr_req && (m_count < DEPTH);
          rok = rd_req && (m_count > 0);
          if (wok || rok) begin
            m_is_wr   = wok && (!rok || !m_last_wr);
            m_last_wr = m_is_wr;
            m_phase   = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else begin
          if (m_is_wr) begin
            m_count++; m_wptr = (m_wptr + 1) % DEPTH;
          end else begin
            m_count--; m_rptr = (m_rptr + 1) % DEPTH;
          end
          m_phase = 0;
        end
      end
    end
  end

  bit ack_seq[$];
  int waddr_q[$];
  int rb_cnt = 0;

  always @(negedge clk) begin
    if (wr_ack === 1'b1) ack_seq.push_back(1'b1);
    if (rd_ack === 1'b1) ack_seq.push_back(1'b0);
    if (RB_LoadEnable === 1'b1) rb_cnt++;
    if (mem_we === 1'b1) waddr_q.push_back(int'(mem_waddr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write();
    int n;
    wr_req = 1'b1;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) break;
    end
    chk("write_ack_within_bound", n < 10, 1);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read();
    int n;
    rd_req = 1'b1;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rd_ack === 1'b1) break;
    end
    chk("read_ack_within_bound", n < 10, 1);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    tick();

    // Read while empty: one rd_err pulse, no read-buffer load.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("empty_rd_err_pulse", rd_err, 1);
    tick();
    @(negedge clk);
    chk("empty_rd_err_clear", rd_err, 0);
    chk("empty_no_rb_load", rb_cnt, 0);
    tick();

    // Single write latency from IDLE.
    wr_req = 1'b1;
    @(negedge clk);
    chk("lat_c0_wb", WB_LoadEnable, 0);
    tick();
    @(negedge clk);
    chk("lat_c1_wb", WB_LoadEnable, 1);
    chk("lat_c1_we", mem_we, 0);
    tick();
    @(negedge clk);
    chk("lat_c2_we", mem_we, 1);
    chk("lat_c2_ack", wr_ack, 1);
    chk("lat_c2_waddr", mem_waddr, 0);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    chk("lat_c3_ack", wr_ack, 0);
    chk("lat_c3_count", count, 1);
    tick();

    // Fill to full, then a rejected write.
    repeat (7) do_write();
    @(negedge clk);
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    tick();
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    chk("full_wr_err_pulse", wr_err, 1);
    chk("full_no_we", mem_we, 0);
    tick();
    @(negedge clk);
    chk("full_wr_err_clear", wr_err, 0);
    chk("full_count_kept", count, 8);
    tick();

    // Simultaneous requests at count=4 alternate starting with write.
    repeat (4) do_read();
    ack_seq.delete();
    wr_req = 1'b1;
    rd_req = 1'b1;
    repeat (12) tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    chk("arb_count", count, 4);
    chk("arb_grants", ack_seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_seq.size()) chk($sformatf("arb_grant_%0d_is_write", i), ack_seq[i], (i % 2) == 0);
    end
    tick();

    // Reset while in WR_COMMIT.
    wr_req = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_wr_ack", wr_ack, 0);
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("abort_count", count, 0);
    chk("abort_empty", empty, 1);
    chk("abort_waddr", mem_waddr, 0);
    tick();

    // Pointer wrap.
    repeat (8) do_write();
    repeat (8) do_read();
    waddr_q.delete();
    repeat (3) do_write();
    @(negedge clk);
    chk("wrap_count", count, 3);
    chk("wrap_writes", waddr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < waddr_q.size()) chk($sformatf("wrap_waddr_%0d", i), waddr_q[i], i);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
